// File: rtl/serial_xnor_comparator.sv
// Serial word-equality checker: takes WIDTH (a, b) bit pairs, one per accepted cycle, and builds
// the XNOR word, the mismatch count and a whole-word equal flag.
module serial_xnor_comparator #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_bit_valid,
  input  logic             i_a_bit,
  input  logic             i_b_bit,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_equal,
  output logic [CNT_W-1:0] o_mismatch_cnt,
  output logic [WIDTH-1:0] o_xnor_word
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e             r_state, w_state;
  logic               r_busy, w_busy;
  logic               r_done, w_done;
  logic               r_equal, w_equal;
  logic [CNT_W-1:0]   r_cnt, w_cnt;
  logic [WIDTH-1:0]   r_word, w_word;
  logic [IDX_W-1:0]   r_idx, w_idx;
  logic               w_mis;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_equal <= 1'b0;
      r_cnt   <= '0;
      r_word  <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_equal <= w_equal;
      r_cnt   <= w_cnt;
      r_word  <= w_word;
      r_idx   <= w_idx;
    end
  end

  always_comb begin
    w_state = r_state;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_equal = r_equal;
    w_cnt   = r_cnt;
    w_word  = r_word;
    w_idx   = r_idx;
    w_mis   = 1'b0;

    unique case (r_state)
      StIdle: begin
        // A pair presented alongside start is not consumed.
        if (i_start) begin
          w_state = StAccum;
          w_busy  = 1'b1;
          w_equal = 1'b0;
          w_cnt   = '0;
          w_word  = '0;
          w_idx   = '0;
        end
      end
      StAccum: begin
        if (i_bit_valid) begin
          w_mis         = i_a_bit ^ i_b_bit;
          w_word[r_idx] = ~w_mis;
          w_cnt         = r_cnt + CNT_W'(w_mis);
          w_idx         = r_idx + IDX_W'(1);
          if (r_idx == LAST_IDX) begin
            w_state = StDone;
            w_busy  = 1'b0;
            w_done  = 1'b1;
            w_equal = (w_cnt == '0);
            w_idx   = '0;
          end
        end
      end
      StDone: begin
        w_state = StIdle;
      end
      default: begin
        w_state = StIdle;
        w_busy  = 1'b0;
      end
    endcase
  end

  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_equal        = r_equal;
  assign o_mismatch_cnt = r_cnt;
  assign o_xnor_word    = r_word;

endmodule

// File: tb/tb_serial_xnor_comparator.sv
// Randomised self-checking bench: expected results come from whole-word arithmetic on the
// operands (XNOR, popcount of XOR, equality), not from bit-level state tracking.
module tb_serial_xnor_comparator;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          bit_valid;
  logic          a_bit;
  logic          b_bit;
  logic          busy;
  logic          done;
  logic          equal;
  logic [CW-1:0] mismatch_cnt;
  logic [W-1:0]  xnor_word;

  int n_cmp;
  int n_bad;

  // Results of the last completed word, which must hold through IDLE.
  logic [W-1:0]  held_word;
  logic [CW-1:0] held_cnt;
  logic          held_eq;

  serial_xnor_comparator #(.WIDTH(W), .CNT_W(CW)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (start),
    .i_bit_valid   (bit_valid),
    .i_a_bit       (a_bit),
    .i_b_bit       (b_bit),
    .o_busy        (busy),
    .o_done        (done),
    .o_equal       (equal),
    .o_mismatch_cnt(mismatch_cnt),
    .o_xnor_word   (xnor_word)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic b, input logic d, input logic e,
                           input logic [CW-1:0] c, input logic [W-1:0] w);
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".done"}, 32'(done), 32'(d));
    check({tag, ".equal"}, 32'(equal), 32'(e));
    check({tag, ".cnt"}, 32'(mismatch_cnt), 32'(c));
    check({tag, ".word"}, 32'(xnor_word), 32'(w));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      start     = 1'b0;
      bit_valid = 1'($urandom);
      a_bit     = 1'($urandom);
      b_bit     = 1'($urandom);
      step();
      check_all("idle_hold", 1'b0, 1'b0, held_eq, held_cnt, held_word);
    end
  endtask

  // Start in IDLE (with a pair presented that must not be consumed), then feed one word.
  task automatic run_word(input logic [W-1:0] a, input logic [W-1:0] b, input int max_gap,
                          input bit noisy_start);
    logic [W-1:0]  mask;
    logic [W-1:0]  diff;
    diff      = a ^ b;
    start     = 1'b1;
    bit_valid = 1'b1;
    a_bit     = 1'b0;
    b_bit     = 1'b1;
    step();
    check_all("start", 1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < int'(W); i++) begin
      int gap;
      gap = (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0));
      for (int g = 0; g < gap; g++) begin
        start     = noisy_start ? 1'($urandom) : 1'b0;
        bit_valid = 1'b0;
        a_bit     = 1'($urandom);
        b_bit     = 1'($urandom);
        step();
        check("gap.busy", 32'(busy), 32'd1);
        check("gap.done", 32'(done), 32'd0);
      end
      start     = (noisy_start && i == 3) ? 1'b1 : 1'b0;
      bit_valid = 1'b1;
      a_bit     = a[i];
      b_bit     = b[i];
      step();
      mask = W'((64'd1 << (i + 1)) - 64'd1);
      if (i < int'(W) - 1) begin
        check_all("accum", 1'b1, 1'b0, 1'b0, CW'($countones(diff & mask)), ~diff & mask);
      end
    end
    held_word = ~diff;
    held_cnt  = CW'($countones(diff));
    held_eq   = (a == b);
    check_all("done", 1'b0, 1'b1, held_eq, held_cnt, held_word);
    // start and bit_valid in the DONE cycle must be ignored.
    start     = 1'b1;
    bit_valid = 1'b1;
    a_bit     = 1'b1;
    b_bit     = 1'b0;
    step();
    check_all("after_done", 1'b0, 1'b0, held_eq, held_cnt, held_word);
    start = 1'b0;
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    held_word = '0;
    held_cnt  = '0;
    held_eq   = 1'b0;
    rst_n     = 1'b0;
    start     = 1'b0;
    bit_valid = 1'b0;
    a_bit     = 1'b0;
    b_bit     = 1'b0;

    // Reset held with random inputs toggling.
    for (int i = 0; i < 4; i++) begin
      start     = 1'($urandom);
      bit_valid = 1'($urandom);
      a_bit     = 1'($urandom);
      b_bit     = 1'($urandom);
      step();
      check_all("reset", 1'b0, 1'b0, 1'b0, '0, '0);
    end
    start = 1'b0;
    #3 rst_n = 1'b1;
    step();
    check_all("post_reset", 1'b0, 1'b0, 1'b0, '0, '0);
    idle_cycles(2);

    run_word(8'hA5, 8'hA5, 0, 1'b0);
    idle_cycles(3);
    run_word(8'hFF, 8'h00, 0, 1'b0);
    idle_cycles(2);
    run_word(8'hCC, 8'hAA, 3, 1'b0);
    check("truth_word", 32'(held_word), 32'h99);
    idle_cycles(1);
    run_word(8'h3C, 8'h3D, 2, 1'b1);

    // Reset after five pairs: outputs clear without waiting for an edge.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bit_valid = 1'b1;
      a_bit     = 1'b1;
      b_bit     = 1'(i & 1);
      step();
    end
    bit_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_all("mid_reset", 1'b0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1;
      step();
      check_all("mid_reset_hold", 1'b0, 1'b0, 1'b0, '0, '0);
    end
    #2 rst_n = 1'b1;
    held_word = '0;
    held_cnt  = '0;
    held_eq   = 1'b0;
    idle_cycles(2);
    run_word(8'h5A, 8'h5A, 0, 1'b0);

    for (int n = 0; n < 25; n++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = W'($urandom);
      case ($urandom_range(3, 0))
        0:       rb = ra;
        1:       rb = ra ^ W'(1 << $urandom_range(W - 1, 0));
        default: rb = W'($urandom);
      endcase
      run_word(ra, rb, 3, 1'($urandom));
      idle_cycles(int'($urandom_range(2, 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_xnor_comparator.md
Name: serial_xnor_comparator

Overview:
- Downstream consumer of the XNOR gate stage: receives bit pairs (a, b) serially, forms the bitwise XNOR of each pair, and assembles a WIDTH-bit equality word.
- Counts mismatching bit positions and flags whole-word equality after WIDTH accepted pairs.
- Used as the sequential word-equality checker in the ALU/comparator path of the computer-organization datapath.

Parameters:
- WIDTH, 8, number of bit pairs per comparison word (2..32).
- CNT_W, 4, width of mismatch counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request new comparison; accepted only in IDLE
- bit_valid  input  1  a_bit/b_bit hold a valid pair this cycle
- a_bit  input  1  serial operand A bit
- b_bit  input  1  serial operand B bit
- busy  output  1  high while in ACCUM
- done  output  1  one-cycle pulse, result valid
- equal  output  1  1 when all WIDTH pairs matched
- mismatch_cnt  output  CNT_W  number of pairs with a_bit != b_bit
- xnor_word  output  WIDTH  collected XNOR results, first pair in bit 0

Behaviour:
- One clock (clk); asynchronous active-low reset (rst_n). All state is registered; all outputs come straight from registers.
- Reset (any time, including mid-word):
  - state=IDLE; busy=0, done=0, equal=0, mismatch_cnt=0, xnor_word=0, internal bit index=0.
  - A partially accumulated word is discarded.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - start=1 at edge k: state goes to ACCUM; xnor_word, mismatch_cnt, equal and index clear to 0; busy=1 from cycle k+1.
  - bit_valid is ignored.
  - Previous results (equal, mismatch_cnt, xnor_word) hold until a start is accepted.
- ACCUM:
  - Each edge with bit_valid=1: xnor_word[index] <= ~(a_bit ^ b_bit).
  - If a_bit != b_bit, mismatch_cnt increments by 1.
  - index increments.
  - bit_valid=0: no change; gaps of any length are allowed.
  - start is ignored.
  - On the edge that consumes pair index WIDTH-1: state goes to DONE, busy drops to 0, and equal <= (final mismatch_cnt == 0), including that last pair's contribution.
- DONE:
  - Lasts exactly one cycle with done=1, then returns to IDLE unconditionally.
  - start and bit_valid are ignored in this cycle.
- Latency:
  - done rises one cycle after the edge that accepts the last pair.
  - Minimum word time is 1 (start) + WIDTH + 1 (done) cycles.
- Per-bit truth (XNOR):
  - (0,0)→1, (0,1)→0, (1,0)→0, (1,1)→1.
- Arithmetic:
  - mismatch_cnt never exceeds WIDTH, so no wrap.
  - index wraps to 0 on entering IDLE.
- Simultaneous events:
  - rst_n low overrides all.
  - start together with bit_valid in IDLE: only the start is acted on; that pair is not consumed.

Test Plan:
- Reset: hold rst_n=0 with random inputs → busy=0, done=0, equal=0, mismatch_cnt=0, xnor_word=8'h00. Release rst_n asynchronously mid-cycle → still IDLE.
- Equal word: start, then 8 consecutive pairs with a=b=8'hA5 (LSB first) → done pulse 1 cycle after 8th pair; equal=1, mismatch_cnt=0, xnor_word=8'hFF; values held in IDLE.
- All-different word: a=8'hFF, b=8'h00 → equal=0, mismatch_cnt=8, xnor_word=8'h00.
- Truth table with gaps: pairs (0,0),(0,1),(1,0),(1,1),(0,0),(0,1),(1,0),(1,1), with bit_valid=0 gaps of 0–3 cycles → xnor_word=8'h99, mismatch_cnt=4, equal=0, busy continuous through the gaps.
- Ignored start: pulse start at index 3 and in the DONE cycle → no restart, result unchanged. A fresh start in IDLE clears the outputs the next cycle.
- Reset mid-operation: assert rst_n=0 after 5 pairs → all outputs 0 immediately, no done pulse. A following full word compares correctly from bit 0.
